// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: forwarding mux codes and
// the data-memory wait FSM state encoding.
package pipe_ctrl_pkg;

  // EXE operand mux selects
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
  localparam logic [1:0] FWD_MEM  = 2'b01;  // ALU result sitting in MEM
  localparam logic [1:0] FWD_WB   = 2'b10;  // value being written back

  // Data-memory wait FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_e;

endpackage

// File: rtl/pipe_ctrl_unit_mem_wait.sv
// Multi-cycle data-memory wait FSM. A load/store holds MEM for MEM_WAIT
// cycles; stall is high for the first MEM_WAIT-1 of them so the pipe holds
// while the access completes. busy mirrors the state bit (high in WAIT).
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_access,
  output logic stall,
  output logic busy
);

  localparam int CW = $clog2(MEM_WAIT) + 1;
  // Cycles still to wait after the first (IDLE) cycle and the final release cycle
  localparam logic [CW-1:0] CNT_INIT = CW'((MEM_WAIT > 1) ? (MEM_WAIT - 2) : 0);

  wait_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_c;

  // Next-state and stall decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_access && (MEM_WAIT > 1)) begin
          stall_c = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          // Release cycle: the access completes, pipe moves on
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces the outputs low in the same cycle, even mid-WAIT
  assign stall = ~rst & stall_c;
  assign busy  = ~rst & (state_q == ST_WAIT);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central pipeline controller: EXE forwarding selects, load-use / RAW hazard
// freeze, branch flush, whole-pipe memory stall and saturating perf counters.
// Priority of pipe controls: stall_all > flush > freeze.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int FORWARD_EN = 1,
  parameter int MEM_WAIT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fwd_en,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_src1,
  input  logic [REG_ADDR_W-1:0] exe_src2,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_access,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  wb_wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  branch_taken,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  freeze,
  output logic                  stall_all,
  output logic                  flush,
  output logic                  mem_busy,
  output logic [CNT_W-1:0]      perf_stall,
  output logic [CNT_W-1:0]      perf_flush
);

  logic             fe;
  logic             match_exe, match_mem, hazard;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

  mem_wait_fsm #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
    .clk        (clk),
    .rst        (rst),
    .mem_access (mem_access),
    .stall      (stall_all),
    .busy       (mem_busy)
  );

  // Forwarding is active only when built in and enabled at run time
  assign fe = (FORWARD_EN != 0) & fwd_en;

  // Hazard detection against the instruction in ID
  always_comb begin
    match_exe = (id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest));
    match_mem = (id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest));
    if (fe) hazard = exe_wb_en & exe_mem_read & match_exe;
    else    hazard = (exe_wb_en & match_exe) | (mem_wb_en & match_mem);
  end

  // Pipe controls; stall_all is already zero during reset
  always_comb begin
    flush  = ~rst & branch_taken & ~stall_all;
    freeze = ~rst & hazard & ~stall_all & ~flush;
  end

  // EXE operand selects; the MEM stage result is younger so it wins
  always_comb begin
    fwd_sel_a = FWD_NONE;
    fwd_sel_b = FWD_NONE;
    if (fe && !rst) begin
      if (mem_wb_en && (mem_dest == exe_src1))    fwd_sel_a = FWD_MEM;
      else if (wb_wb_en && (wb_dest == exe_src1)) fwd_sel_a = FWD_WB;
      if (mem_wb_en && (mem_dest == exe_src2))    fwd_sel_b = FWD_MEM;
      else if (wb_wb_en && (wb_dest == exe_src2)) fwd_sel_b = FWD_WB;
    end
  end

  // Saturating counter increments
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if ((freeze | stall_all) && !(&perf_stall_q)) perf_stall_d = perf_stall_q + CNT_W'(1);
    if (flush && !(&perf_flush_q))                perf_flush_d = perf_flush_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = rst ? '0 : perf_stall_q;
  assign perf_flush = rst ? '0 : perf_flush_q;

endmodule
